csr_counter_file: RTL and testbench
===================================

# csr_counter_file

Machine-mode counter/timer CSR file for the core's CSR unit: two 64-bit event counters (cycle, instructions-retired) with an inhibit register, plus the CSR read/write port that the CSR instruction path uses to access them. It consumes the retire strobe from the writeback stage. It returns registered read data and an access-error flag to the CSR unit one cycle after each access.

## Interface
- XLEN, 32, CSR data width; the counters are 2*XLEN bits wide.

- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- retire_i  in  1  one instruction retired this cycle
- csr_rd_en_i  in  1  CSR read access this cycle
- csr_wr_en_i  in  1  CSR write access this cycle
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  XLEN  write data
- csr_rdata_o  out  XLEN  registered read data
- csr_rvalid_o  out  1  access response valid (registered)
- csr_err_o  out  1  access error (registered, qualified by csr_rvalid_o)

## Operation
- Address map:
  - 0xB00 mcycle[31:0], 0xB80 mcycleh[63:32], 0xB02 minstret[31:0], 0xB82 minstreth[63:32]: read/write.
  - 0xC00 cycle, 0xC80 cycleh, 0xC02 instret, 0xC82 instreth: read-only aliases of the same counters.
  - 0x320 mcountinhibit: bit0 = CY, bit2 = IR, both writable; all other bits read 0 and ignore writes.
- Cycle counter increments by 1 every clk when CY=0.
- Instret counter increments by 1 when retire_i=1 and IR=0.
- Counters wrap: 0xFFFFFFFF_FFFFFFFF + 1 -> 0.
- A carry out of the low half propagates to the high half in the same cycle.
- Write to a low half:
  - low half <= csr_wdata_i;
  - high half unchanged;
  - that counter's increment is suppressed this cycle (write wins).
- Write to a high half:
  - high half <= csr_wdata_i;
  - low half still increments normally;
  - any carry into the high half this cycle is discarded.
- Write to mcountinhibit takes effect from the next cycle. The current cycle's increment uses the old inhibit value.
- Error cases, each giving csr_err_o=1 and csr_rdata_o=0 with no state change:
  - any access to an unmapped address;
  - a write to a 0xCxx read-only alias.
- Read and write to the same address in the same cycle: csr_rdata_o returns the pre-write value (CSRRW semantics), and the write then applies.
- Reads sample counter state before the clock edge that updates it.

## Timing
- Reset (rst_n=0, asynchronous): both counters 0, mcountinhibit 0, csr_rdata_o 0, csr_rvalid_o 0, csr_err_o 0. All outputs are held at 0 while reset is asserted.
- Response latency: csr_rvalid_o=1 exactly one cycle after any cycle with csr_rd_en_i or csr_wr_en_i high.
  - A single-cycle pulse per access.
  - Back-to-back accesses give back-to-back responses.
- On a write-only access, csr_rdata_o is 0 in the response cycle.
- Counting starts the first clk edge after reset deasserts. The first cycle read at that point returns 0.
- Reset asserted mid-access: the pending response is dropped and csr_rvalid_o stays 0.
- Simultaneous events within one cycle (all resolved together):
  - counter write + increment + inhibit write + read;
  - priority per half: write > increment.
- The block sits on the CSR path only. It has no combinational path from inputs to outputs.

## Test plan
- Reset, then idle 10 cycles with CY=0, read 0xB00 -> csr_rdata_o=10 one cycle later, csr_rvalid_o=1, csr_err_o=0.
- Write 0xB00=0xFFFFFFFF and 0xB80=0x00000005, then idle 1 cycle and read 0xB80 -> 0x00000006 (carry propagated); 0xB00 reads small value post-wrap.
- Write 0x320=0x4 then pulse retire_i 5 times, read 0xB02 -> 0; write 0x320=0x0, pulse retire_i 3 times -> 3; read 0x320 after writing 0xFFFFFFFF -> 0x00000005.
- Same-cycle read+write 0xB02 with wdata 0x100 while retire_i=1 -> rdata = old value; next read -> 0x100 (increment suppressed).
- Write 0xC00 and read 0x7FF -> csr_err_o=1, csr_rdata_o=0, counters unaffected; read 0xC80 returns same value as 0xB80.
- Assert rst_n=0 mid-count with a read issued in the same cycle -> all outputs 0 immediately, no response pulse; counters restart from 0.

Source files
------------

// File: rtl/csr_counter_file_if.sv
// CSR access port between the CSR instruction path (master) and the counter/timer CSR file (slave).
interface csr_counter_file_if #(
    parameter int XLEN = 32
);
    logic            csr_rd_en_i;
    logic            csr_wr_en_i;
    logic [11:0]     csr_addr_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            csr_rvalid_o;
    logic            csr_err_o;

    modport master (
        output csr_rd_en_i, csr_wr_en_i, csr_addr_i, csr_wdata_i,
        input  csr_rdata_o, csr_rvalid_o, csr_err_o
    );

    modport slave (
        input  csr_rd_en_i, csr_wr_en_i, csr_addr_i, csr_wdata_i,
        output csr_rdata_o, csr_rvalid_o, csr_err_o
    );
endinterface

// File: rtl/csr_counter_file.sv
// Machine-mode cycle/instret counters with mcountinhibit, accessed over a registered CSR port.
module csr_counter_file #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             retire_i,
    csr_counter_file_if.slave csr
);
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_INHIBIT   = 12'h320;

    logic [2*XLEN-1:0] mcycle_q, minstret_q;
    logic              inh_cy_q, inh_ir_q;

    logic              sel_cy_lo, sel_cy_hi, sel_ir_lo, sel_ir_hi, sel_inh;
    logic              is_alias, mapped, access, err, wr_ok;
    logic [XLEN-1:0]   rdata_nxt;

    logic [XLEN-1:0]   rdata_p1;
    logic              vld_p1, err_p1;

    // Write on a half wins over the increment; a high-half write drops this cycle's carry.
    function automatic logic [2*XLEN-1:0] cnt_next(
        input logic [2*XLEN-1:0] cur,
        input logic              inc,
        input logic              wr_lo,
        input logic              wr_hi,
        input logic [XLEN-1:0]   wdata
    );
        logic [2*XLEN-1:0] sum;
        sum = cur + {{(2*XLEN-1){1'b0}}, inc};
        if (wr_lo)
            cnt_next = {cur[2*XLEN-1:XLEN], wdata};
        else if (wr_hi)
            cnt_next = {wdata, sum[XLEN-1:0]};
        else
            cnt_next = sum;
    endfunction

    always_comb begin
        sel_cy_lo = (csr.csr_addr_i == A_MCYCLE)    || (csr.csr_addr_i == A_CYCLE);
        sel_cy_hi = (csr.csr_addr_i == A_MCYCLEH)   || (csr.csr_addr_i == A_CYCLEH);
        sel_ir_lo = (csr.csr_addr_i == A_MINSTRET)  || (csr.csr_addr_i == A_INSTRET);
        sel_ir_hi = (csr.csr_addr_i == A_MINSTRETH) || (csr.csr_addr_i == A_INSTRETH);
        sel_inh   = (csr.csr_addr_i == A_INHIBIT);
        is_alias  = (csr.csr_addr_i[11:8] == 4'hC);
        mapped    = sel_cy_lo || sel_cy_hi || sel_ir_lo || sel_ir_hi || sel_inh;
        access    = csr.csr_rd_en_i || csr.csr_wr_en_i;
        err       = access && (!mapped || (csr.csr_wr_en_i && is_alias));
        wr_ok     = csr.csr_wr_en_i && !err;

        rdata_nxt = '0;
        if (csr.csr_rd_en_i && !err) begin
            if (sel_cy_lo)      rdata_nxt = mcycle_q[XLEN-1:0];
            else if (sel_cy_hi) rdata_nxt = mcycle_q[2*XLEN-1:XLEN];
            else if (sel_ir_lo) rdata_nxt = minstret_q[XLEN-1:0];
            else if (sel_ir_hi) rdata_nxt = minstret_q[2*XLEN-1:XLEN];
            else begin
                rdata_nxt[0] = inh_cy_q;
                rdata_nxt[2] = inh_ir_q;
            end
        end
    end

    // p0 -> p1: counters, inhibit and the registered access response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            inh_cy_q   <= 1'b0;
            inh_ir_q   <= 1'b0;
            rdata_p1   <= '0;
            vld_p1     <= 1'b0;
            err_p1     <= 1'b0;
        end else begin
            mcycle_q   <= cnt_next(mcycle_q, !inh_cy_q, wr_ok && sel_cy_lo,
                                   wr_ok && sel_cy_hi, csr.csr_wdata_i);
            minstret_q <= cnt_next(minstret_q, retire_i && !inh_ir_q, wr_ok && sel_ir_lo,
                                   wr_ok && sel_ir_hi, csr.csr_wdata_i);
            if (wr_ok && sel_inh) begin
                inh_cy_q <= csr.csr_wdata_i[0];
                inh_ir_q <= csr.csr_wdata_i[2];
            end
            rdata_p1   <= rdata_nxt;
            vld_p1     <= access;
            err_p1     <= err;
        end
    end

    assign csr.csr_rdata_o  = rdata_p1;
    assign csr.csr_rvalid_o = vld_p1;
    assign csr.csr_err_o    = err_p1;
endmodule

// File: tb/tb_csr_counter_file.sv
// Directed bench for csr_counter_file: counting, wrap/carry, inhibit, CSRRW, errors and reset.
module tb_csr_counter_file;
    logic clk;
    logic rst_n;
    logic retire;
    int   n_assert;
    int   n_fail;

    csr_counter_file_if #(.XLEN(32)) bus ();

    csr_counter_file #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .retire_i (retire),
        .csr      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives one access for one cycle and checks its response.
    task automatic op(input logic rd, input logic wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_d,
                      input logic exp_e, input string tag);
        bus.csr_rd_en_i = rd;
        bus.csr_wr_en_i = wr;
        bus.csr_addr_i  = a;
        bus.csr_wdata_i = wd;
        @(negedge clk);
        bus.csr_rd_en_i = 1'b0;
        bus.csr_wr_en_i = 1'b0;
        bus.csr_addr_i  = 12'h000;
        bus.csr_wdata_i = 32'h0;
        chk({tag, ".vld"}, {31'b0, bus.csr_rvalid_o}, 32'd1);
        chk({tag, ".err"}, {31'b0, bus.csr_err_o}, {31'b0, exp_e});
        chk({tag, ".data"}, bus.csr_rdata_o, exp_d);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            retire = 1'b1;
            @(negedge clk);
        end
        retire = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        retire   = 1'b0;
        bus.csr_rd_en_i = 1'b0;
        bus.csr_wr_en_i = 1'b0;
        bus.csr_addr_i  = 12'h000;
        bus.csr_wdata_i = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst.vld",  {31'b0, bus.csr_rvalid_o}, 32'd0);
        chk("rst.err",  {31'b0, bus.csr_err_o}, 32'd0);
        chk("rst.data", bus.csr_rdata_o, 32'd0);
        rst_n = 1'b1;

        // cycle counts 10 idle edges
        repeat (10) @(negedge clk);
        op(1, 0, 12'hB00, 0, 32'd10, 0, "cyc10");

        // carry propagation low -> high
        op(0, 1, 12'hB80, 32'h5, 32'h0, 0, "w_hi5");
        op(0, 1, 12'hB00, 32'hFFFF_FFFF, 32'h0, 0, "w_loff");
        @(negedge clk);
        op(1, 0, 12'hB80, 0, 32'h6, 0, "carry_hi");
        op(1, 0, 12'hB00, 0, 32'h1, 0, "carry_lo");

        // high-half write in the wrap cycle discards the carry
        op(0, 1, 12'hB00, 32'hFFFF_FFFF, 32'h0, 0, "w_loff2");
        op(0, 1, 12'hB80, 32'h10, 32'h0, 0, "w_hi10");
        op(1, 0, 12'hB80, 0, 32'h10, 0, "nocarry_hi");
        op(1, 0, 12'hB00, 0, 32'h1, 0, "nocarry_lo");
        op(1, 0, 12'hC80, 0, 32'h10, 0, "alias_hi");

        // full 64-bit wrap
        op(0, 1, 12'hB80, 32'hFFFF_FFFF, 32'h0, 0, "w_hiff");
        op(0, 1, 12'hB00, 32'hFFFF_FFFF, 32'h0, 0, "w_loff3");
        @(negedge clk);
        op(1, 0, 12'hB80, 0, 32'h0, 0, "wrap_hi");
        op(1, 0, 12'hB00, 0, 32'h1, 0, "wrap_lo");

        // instret with IR inhibit
        op(0, 1, 12'h320, 32'h4, 32'h0, 0, "inh_ir");
        pulses(5);
        op(1, 0, 12'hB02, 0, 32'h0, 0, "ir_frozen");
        op(0, 1, 12'h320, 32'h0, 32'h0, 0, "inh_clr");
        pulses(3);
        op(1, 0, 12'hB02, 0, 32'h3, 0, "ir_3");
        op(0, 1, 12'h320, 32'hFFFF_FFFF, 32'h0, 0, "inh_all");
        @(negedge clk);
        chk("idle.vld", {31'b0, bus.csr_rvalid_o}, 32'd0);
        op(1, 0, 12'h320, 0, 32'h5, 0, "inh_rd");
        op(1, 0, 12'hB00, 0, 32'd15, 0, "cy_frozen1");
        op(1, 0, 12'hB00, 0, 32'd15, 0, "cy_frozen2");

        // inhibit clear alongside retire: old inhibit governs this cycle
        retire = 1'b1;
        op(0, 1, 12'h320, 32'h0, 32'h0, 0, "inh_clr2");
        retire = 1'b0;
        op(1, 0, 12'hB02, 0, 32'h3, 0, "ir_old_inh");
        op(1, 0, 12'hB00, 0, 32'd16, 0, "cy_resume");

        // CSRRW on minstret with retire: old value returned, write wins
        retire = 1'b1;
        op(1, 1, 12'hB02, 32'h100, 32'h3, 0, "rw_ir");
        retire = 1'b0;
        op(1, 0, 12'hB02, 0, 32'h100, 0, "rw_after");
        op(1, 0, 12'hC02, 0, 32'h100, 0, "alias_ir");
        op(1, 0, 12'hC82, 0, 32'h0, 0, "alias_irh");

        // error cases
        op(0, 1, 12'hC00, 32'h0, 32'h0, 1, "err_wro");
        op(1, 0, 12'h7FF, 0, 32'h0, 1, "err_unmap");
        op(1, 1, 12'hC02, 32'h55, 32'h0, 1, "err_rwro");
        op(1, 0, 12'hB02, 0, 32'h100, 0, "ir_kept");
        op(1, 0, 12'hB00, 0, 32'd25, 0, "cy_kept");
        op(1, 0, 12'hB80, 0, 32'h0, 0, "cyh_b80");
        op(1, 0, 12'hC80, 0, 32'h0, 0, "cyh_c80");

        // reset mid-access
        op(0, 1, 12'h320, 32'h5, 32'h0, 0, "inh_pre");
        bus.csr_rd_en_i = 1'b1;
        bus.csr_addr_i  = 12'hB02;
        @(negedge clk);
        chk("pre.vld", {31'b0, bus.csr_rvalid_o}, 32'd1);
        chk("pre.data", bus.csr_rdata_o, 32'h100);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.vld",  {31'b0, bus.csr_rvalid_o}, 32'd0);
        chk("arst.data", bus.csr_rdata_o, 32'd0);
        chk("arst.err",  {31'b0, bus.csr_err_o}, 32'd0);
        @(negedge clk);
        bus.csr_rd_en_i = 1'b0;
        bus.csr_addr_i  = 12'h000;
        chk("drop.vld", {31'b0, bus.csr_rvalid_o}, 32'd0);
        rst_n = 1'b1;
        op(1, 0, 12'hB00, 0, 32'd0, 0, "post_cy0");
        op(1, 0, 12'hB00, 0, 32'd1, 0, "post_cy1");
        op(1, 0, 12'h320, 0, 32'd0, 0, "post_inh");
        op(1, 0, 12'hB02, 0, 32'd0, 0, "post_ir");
        op(1, 0, 12'hB80, 0, 32'd0, 0, "post_cyh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
